// File: rtl/aes_dec_pkg.sv
// Shared types, InvMixColumns coefficients, scheduler states and the GF(2^8)
// multiplier used by the AES decryption datapath.
package aes_dec_pkg;

   typedef logic [127:0] aes_block_t;
   typedef logic [31:0]  aes_col_t;

   localparam logic [7:0] INV_MIX_E = 8'h0e;
   localparam logic [7:0] INV_MIX_B = 8'h0b;
   localparam logic [7:0] INV_MIX_D = 8'h0d;
   localparam logic [7:0] INV_MIX_9 = 8'h09;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} inv_mix_sched_state_t;

   // Shift-and-add multiply over GF(2^8) mod 0x11b; constant b folds to XOR trees.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] x;
      acc = '0;
      x   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational single-column InvMixColumns; byte a0 is the column MSB.
module inv_mix_column
   import aes_dec_pkg::*;
(
   input  aes_col_t col,
   output aes_col_t mixed
);

   logic [7:0] a0, a1, a2, a3;

   assign {a0, a1, a2, a3} = col;

   assign mixed[31:24] = gf_mul(a0, INV_MIX_E) ^ gf_mul(a1, INV_MIX_B)
                       ^ gf_mul(a2, INV_MIX_D) ^ gf_mul(a3, INV_MIX_9);
   assign mixed[23:16] = gf_mul(a0, INV_MIX_9) ^ gf_mul(a1, INV_MIX_E)
                       ^ gf_mul(a2, INV_MIX_B) ^ gf_mul(a3, INV_MIX_D);
   assign mixed[15:8]  = gf_mul(a0, INV_MIX_D) ^ gf_mul(a1, INV_MIX_9)
                       ^ gf_mul(a2, INV_MIX_E) ^ gf_mul(a3, INV_MIX_B);
   assign mixed[7:0]   = gf_mul(a0, INV_MIX_B) ^ gf_mul(a1, INV_MIX_D)
                       ^ gf_mul(a2, INV_MIX_9) ^ gf_mul(a3, INV_MIX_E);

endmodule

// File: rtl/inv_mix_columns_sched.sv
// Column-serial InvMixColumns scheduler: LANES columns per cycle, bypass for the final round.
// Optional stall counter output enabled by INV_MIX_COLUMNS_SCHED_STALL_CNT_EN.
module inv_mix_columns_sched
   import aes_dec_pkg::*;
#(
   parameter int LANES = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         valid_i,
   output logic         ready_o,
   input  logic [127:0] block_i,
   input  logic         bypass_i,
   output logic         valid_o,
   input  logic         ready_i,
   output logic [127:0] mixed_o
`ifdef INV_MIX_COLUMNS_SCHED_STALL_CNT_EN
   ,
   output logic [15:0]  stall_cnt_o
`endif
);

   localparam int STEPS = 4 / LANES;

   if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
      $error("inv_mix_columns_sched: LANES must be 1, 2 or 4");
   end

   inv_mix_sched_state_t state, state_nxt;
   logic [1:0]           step;
   logic                 last_step;
   logic [3:0][31:0]     blk_q;
   logic [3:0][31:0]     mix_q;

   logic [LANES-1:0][1:0]  lane_idx;
   logic [LANES-1:0][31:0] lane_in;
   logic [LANES-1:0][31:0] lane_out;

   assign last_step = (step == 2'(STEPS - 1));

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lane_idx[l] = 2'(32'(step) * LANES + l);
      assign lane_in[l]  = blk_q[lane_idx[l]];
      inv_mix_column u_col (
         .col   (lane_in[l]),
         .mixed (lane_out[l])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (valid_i) state_nxt = bypass_i ? DONE : BUSY;
         BUSY: if (last_step) state_nxt = DONE;
         DONE: if (ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: latch on accept, overwrite the scheduled columns each BUSY cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         blk_q <= '0;
         mix_q <= '0;
         step  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (valid_i && bypass_i) mix_q <= block_i;
               if (valid_i && !bypass_i) begin
                  blk_q <= block_i;
                  step  <= '0;
               end
            end
            BUSY: begin
               for (int l = 0; l < LANES; l++) mix_q[lane_idx[l]] <= lane_out[l];
               step <= last_step ? 2'd0 : step + 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign ready_o = rst_n && (state == IDLE);
   assign valid_o = (state == DONE);
   assign mixed_o = mix_q;

`ifdef INV_MIX_COLUMNS_SCHED_STALL_CNT_EN
   logic [15:0] stall_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (valid_o && !ready_i && stall_cnt != 16'hffff)
         stall_cnt <= stall_cnt + 16'd1;
   end

   assign stall_cnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_inv_mix_columns_sched.sv
// Bench for inv_mix_columns_sched: one instance each of LANES = 1, 2, 4, table vectors,
// directed backpressure/reset sequences and a randomized run against a GF(2^8) model.
module tb_inv_mix_columns_sched;

   logic         clk;
   logic         rst_n;
   logic [2:0]   valid_i, bypass_i, ready_i, ready_o, valid_o;
   logic [127:0] block_i [3];
   logic [127:0] mixed_o [3];
`ifdef INV_MIX_COLUMNS_SCHED_STALL_CNT_EN
   logic [15:0]  stall_cnt [3];
`endif

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      inv_mix_columns_sched #(.LANES(1 << g)) u_dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .valid_i     (valid_i[g]),
         .ready_o     (ready_o[g]),
         .block_i     (block_i[g]),
         .bypass_i    (bypass_i[g]),
         .valid_o     (valid_o[g]),
         .ready_i     (ready_i[g]),
         .mixed_o     (mixed_o[g])
`ifdef INV_MIX_COLUMNS_SCHED_STALL_CNT_EN
         ,
         .stall_cnt_o (stall_cnt[g])
`endif
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   // Reference: textbook polynomial multiply then reduce modulo 0x11b.
   function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
      int p;
      int x;
      p = 0;
      x = int'(a);
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x << 1;
      end
      for (int i = 14; i >= 8; i--)
         if (p[i]) p = p ^ (32'h11b << (i - 8));
      return p[7:0];
   endfunction

   // Circulant matrix: row r, input byte j uses coefficient index (j - r) mod 4.
   function automatic logic [127:0] ref_imc(input logic [127:0] b);
      logic [7:0]   coef [4];
      logic [127:0] r;
      logic [7:0]   acc;
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
      r = '0;
      for (int c = 0; c < 4; c++)
         for (int row = 0; row < 4; row++) begin
            acc = '0;
            for (int j = 0; j < 4; j++)
               acc = acc ^ ref_mul(coef[(j - row) & 3], b[32*c + 8*(3-j) +: 8]);
            r[32*c + 8*(3-row) +: 8] = acc;
         end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One block through instance k with ready_i held high.
   task automatic run_one(input int k, input logic [127:0] blk, input logic byp,
                          input logic [127:0] exp, input string nm);
      int   acc, g;
      logic busy_ok;
      ready_i[k] = 1'b1;
      block_i[k] = blk;
      bypass_i[k] = byp;
      valid_i[k] = 1'b1;
      g = 0;
      while (!ready_o[k] && g < 50) begin tick(); g++; end
      chk($sformatf("%s_accept_l%0d", nm, 1 << k), 128'(ready_o[k]), 128'd1);
      acc = cyc;
      tick();
      valid_i[k] = 1'b0;
      busy_ok = 1'b1;
      g = 0;
      while (!valid_o[k] && g < 50) begin
         if (ready_o[k]) busy_ok = 1'b0;
         tick();
         g++;
      end
      if (ready_o[k]) busy_ok = 1'b0;
      chk($sformatf("%s_latency_l%0d", nm, 1 << k), 128'(cyc - acc),
          byp ? 128'd1 : 128'((4 >> k) + 1));
      chk($sformatf("%s_data_l%0d", nm, 1 << k), mixed_o[k], exp);
      chk($sformatf("%s_ready_low_l%0d", nm, 1 << k), 128'(busy_ok), 128'd1);
      tick();
      chk($sformatf("%s_handoff_l%0d", nm, 1 << k), 128'({valid_o[k], ready_o[k]}), 128'd1);
   endtask

   task automatic run_random(input int k, input int num);
      logic [127:0] expq [$];
      logic [127:0] blk;
      logic         byp;
      int           got;
      fork
         begin : drv
            int g;
            for (int n = 0; n < num; n++) begin
               valid_i[k] = 1'b0;
               repeat ($urandom_range(0, 2)) tick();
               blk = {$urandom, $urandom, $urandom, $urandom};
               byp = ($urandom_range(0, 3) == 0);
               block_i[k] = blk;
               bypass_i[k] = byp;
               valid_i[k] = 1'b1;
               g = 0;
               while (!ready_o[k] && g < 100) begin tick(); g++; end
               if (g >= 100) begin
                  chk($sformatf("rnd_accept_timeout_l%0d", 1 << k), 128'd0, 128'd1);
                  break;
               end
               expq.push_back(byp ? blk : ref_imc(blk));
               tick();
            end
            valid_i[k] = 1'b0;
         end
         begin : mon
            int g;
            got = 0;
            g = 0;
            while (got < num && g < num * 40) begin
               tick();
               g++;
               ready_i[k] = 1'($urandom_range(0, 1));
               if (valid_o[k] && ready_i[k]) begin
                  if (expq.size() == 0)
                     chk($sformatf("rnd_extra_l%0d", 1 << k), 128'd1, 128'd0);
                  else
                     chk($sformatf("rnd_data_l%0d_n%0d", 1 << k, got), mixed_o[k],
                         expq.pop_front());
                  got++;
               end
            end
         end
      join
      tick();
      ready_i[k] = 1'b0;
      chk($sformatf("rnd_count_l%0d", 1 << k), 128'(got), 128'(num));
      chk($sformatf("rnd_leftover_l%0d", 1 << k), 128'(expq.size()), 128'd0);
   endtask

   typedef struct {
      logic [127:0] blk;
      logic         byp;
      logic [127:0] exp;
      string        nm;
   } vec_t;

   initial begin
      vec_t         tbl [5];
      logic [127:0] blk_a, blk_b;
      logic         ok;
      int           acc, g;

      tbl[0] = '{128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, 1'b0,
                 128'hdb135345_f20a225c_01010101_d4d4d4d5, "vec_spec"};
      tbl[1] = '{128'h00112233_44556677_8899aabb_ccddeeff, 1'b1,
                 128'h00112233_44556677_8899aabb_ccddeeff, "vec_bypass"};
      tbl[2] = '{128'hffffffff_ffffffff_ffffffff_ffffffff, 1'b0,
                 128'hffffffff_ffffffff_ffffffff_ffffffff, "vec_ones"};
      tbl[3] = '{128'h0, 1'b0, 128'h0, "vec_zero"};
      tbl[4] = '{128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, 1'b1,
                 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, "vec_spec_byp"};

      rst_n = 1'b0;
      valid_i = '0; bypass_i = '0; ready_i = '0;
      for (int k = 0; k < 3; k++) block_i[k] = '0;
      repeat (3) tick();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_valid_l%0d", 1 << k), 128'(valid_o[k]), 128'd0);
         chk($sformatf("rst_mixed_l%0d", 1 << k), mixed_o[k], 128'd0);
         chk($sformatf("rst_ready_low_l%0d", 1 << k), 128'(ready_o[k]), 128'd0);
      end
      rst_n = 1'b1;
      #1;
      chk("rst_ready_high", 128'(ready_o), 128'b111);
      tick();

      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 5; i++)
            run_one(k, tbl[i].blk, tbl[i].byp, tbl[i].exp, tbl[i].nm);

      // Backpressure on LANES=1: hold ready_i low for 10 DONE cycles with a new block pending.
      rst_n = 1'b0; ready_i = '0; valid_i = '0;
      tick();
      rst_n = 1'b1;
      blk_a = tbl[0].blk;
      blk_b = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
      block_i[0] = blk_a; bypass_i[0] = 1'b0; valid_i[0] = 1'b1;
      tick();
      block_i[0] = blk_b;
      g = 0;
      while (!valid_o[0] && g < 50) begin tick(); g++; end
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (!(valid_o[0] && !ready_o[0] && mixed_o[0] == tbl[0].exp)) ok = 1'b0;
         tick();
      end
      chk("bp_hold", 128'(ok), 128'd1);
      chk("bp_data", mixed_o[0], tbl[0].exp);
`ifdef INV_MIX_COLUMNS_SCHED_STALL_CNT_EN
      chk("bp_stall_cnt", 128'(stall_cnt[0]), 128'd10);
`endif
      ready_i[0] = 1'b1;
      tick();
      chk("bp_idle_ready", 128'({valid_o[0], ready_o[0]}), 128'd1);
      acc = cyc;
      tick();
      valid_i[0] = 1'b0;
      g = 0;
      while (!valid_o[0] && g < 50) begin tick(); g++; end
      chk("bp_second_latency", 128'(cyc - acc), 128'd5);
      chk("bp_second_data", mixed_o[0], ref_imc(blk_b));
      tick();

      // Reset during BUSY step 1 on LANES=1.
      ready_i[0] = 1'b1;
      block_i[0] = tbl[0].blk; bypass_i[0] = 1'b0; valid_i[0] = 1'b1;
      g = 0;
      while (!ready_o[0] && g < 50) begin tick(); g++; end
      tick();
      valid_i[0] = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready_comb", 128'(ready_o[0]), 128'd0);
      tick();
      chk("mid_rst_valid", 128'(valid_o[0]), 128'd0);
      chk("mid_rst_mixed", mixed_o[0], 128'd0);
      chk("mid_rst_ready_held", 128'(ready_o[0]), 128'd0);
      rst_n = 1'b1;
      #1;
      chk("mid_rst_ready_after", 128'(ready_o[0]), 128'd1);
      run_one(0, tbl[0].blk, 1'b0, tbl[0].exp, "post_rst");

      for (int k = 0; k < 3; k++) run_random(k, 1000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/inv_mix_columns_sched.md
Name: inv_mix_columns_sched

Overview:
Column-serial scheduler for the InvMixColumns step of the multicycle AES decryption chip. It accepts one 128-bit state, drives LANES single-column InvMixColumns datapath instances over 4/LANES cycles, and assembles and holds the result. LANES trades area for latency. It sits between the round datapath register and the AddRoundKey stage. A bypass request serves the final round, which has no InvMixColumns.

Parameters:
LANES, 1, columns processed per cycle; legal values 1, 2, 4; any other value is an elaboration error.
STEPS, 4/LANES, derived localparam; number of BUSY cycles.

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
valid_i  input  1  input block valid
ready_o  output  1  scheduler can accept a block
block_i  input  128  state in; column c = block_i[32c+31:32c], row 0 byte in the MSB
bypass_i  input  1  sampled with block_i; 1 = pass through unchanged
valid_o  output  1  result valid
ready_i  input  1  consumer accepts the result
mixed_o  output  128  result block, same byte mapping as block_i

Behaviour:
- Synchronous, active-low reset; takes effect at the next edge, including mid-operation. Resulting state: IDLE, step counter 0, valid_o 0, mixed_o 128'h0, internal block register 0. While rst_n = 0, ready_o is 0 (combinationally gated).
- States and transitions:
  - IDLE: ready_o = 1.
    - valid_i = 1 and bypass_i = 0: latch block_i, step = 0, go to BUSY.
    - valid_i = 1 and bypass_i = 1: mixed_o <= block_i, go to DONE.
  - BUSY: ready_o = 0. Each cycle, columns step*LANES .. step*LANES+LANES-1 of the latched block pass through the column datapath and are written into the same column positions of mixed_o. Other columns are untouched. Step increments each cycle. At step = STEPS-1, go to DONE. valid_i is ignored.
  - DONE: valid_o = 1 and ready_o = 0. mixed_o and valid_o are held stable until ready_i = 1. On ready_i = 1, go to IDLE with valid_o = 0. mixed_o keeps its value.
- Column math, per column with bytes a0..a3 (a0 = MSB):
  - r0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3
  - r1 = 09·a0 ^ 0e·a1 ^ 0b·a2 ^ 0d·a3
  - r2 = 0d·a0 ^ 09·a1 ^ 0e·a2 ^ 0b·a3
  - r3 = 0b·a0 ^ 0d·a1 ^ 09·a2 ^ 0e·a3
  - Multiplication is GF(2^8) with polynomial 0x11b.
- Latency, counted from the accept edge to the first cycle valid_o = 1:
  - Normal: STEPS+1 cycles, i.e. 5, 3 or 2 for LANES = 1, 2, 4.
  - Bypass: 1 cycle.
- Throughput: at most one block per STEPS+2 cycles. There is no accept in the same cycle as a DONE handoff.
- Outputs are registered. ready_o decodes from state only, with no combinational path from valid_i or ready_i.
- valid_o is never asserted in IDLE or BUSY.

Optional Feature:
- Macro: INV_MIX_COLUMNS_SCHED_STALL_CNT_EN.
- Defined: adds output stall_cnt_o [15:0].
  - Counts cycles with valid_o = 1 and ready_i = 0.
  - Saturates at 16'hffff.
  - Cleared by reset only.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- Package aes_dec_pkg:
  - aes_block_t (logic [127:0]) and aes_col_t (logic [31:0]).
  - Constants INV_MIX_E = 8'h0e, INV_MIX_B = 8'h0b, INV_MIX_D = 8'h0d, INV_MIX_9 = 8'h09.
  - Enum inv_mix_sched_state_t {IDLE, BUSY, DONE}.
- Sub-module inv_mix_column: combinational 32-bit single-column InvMixColumns built from the existing multiplier. It is instantiated LANES times inside a generate loop.

Test Plan:
- LANES = 1; block_i = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, bypass 0, ready_i held 1.
  -> valid_o rises 5 cycles after accept.
  -> mixed_o = 128'hdb135345_f20a225c_01010101_d4d4d4d5.
  -> ready_o = 0 throughout BUSY/DONE.
- Same vector at LANES = 2 and LANES = 4.
  -> Identical mixed_o; valid_o after 3 and 2 cycles respectively.
- bypass_i = 1, block_i = 128'h00112233_44556677_8899aabb_ccddeeff.
  -> valid_o next cycle with mixed_o equal to the input.
- Backpressure: ready_i = 0 for 10 cycles in DONE, while valid_i = 1 with a new block.
  -> mixed_o and valid_o stable; new block not accepted.
  -> With the macro defined, stall_cnt_o = 10.
  -> After ready_i = 1, the second block is accepted.
- rst_n = 0 during BUSY step 1 with LANES = 1.
  -> Next edge: valid_o = 0, mixed_o = 0, state IDLE.
  -> ready_o = 0 while rst_n is low and 1 afterwards.
  -> A subsequent block is processed correctly.
- Random regression: 1000 random blocks with random ready_i and bypass_i.
  -> Every result matches a reference InvMixColumns model.
  -> No block is dropped or duplicated.
